// File: rtl/alloc_ctrl.sv
// Rename/dispatch allocation controller: admits whole 4-slot groups against ROB and
// physical-register free counts, and sequences mispredict recovery through a FLUSH state.
module alloc_ctrl #(
    parameter int ROB_DEPTH = 64,
    parameter int PR_POOL   = 64,
    parameter int FLUSH_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       grp_val_in,
    input  logic [3:0] inst_val_in,
    input  logic [3:0] pr_need_in,
    input  logic       flush_in,
    input  logic [2:0] rob_cmt_cnt_in,
    input  logic [2:0] pr_ret_cnt_in,
    output logic       grp_ack_out,
    output logic [3:0] rob_alloc_en_out,
    output logic [3:0] pr_alloc_en_out,
    output logic       stall_out,
    output logic [6:0] rob_free_out,
    output logic [6:0] pr_free_out,
    output logic [1:0] state_out,
    output logic       err_out
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [7:0]      ROB_MAX  = 8'(ROB_DEPTH);
    localparam logic [7:0]      PR_MAX   = 8'(PR_POOL);
    localparam logic [FC_W-1:0] FLUSH_LD = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [6:0]      rob_free_q, rob_free_d;
    logic [6:0]      pr_free_q, pr_free_d;
    logic            err_q, err_d;

    logic [2:0] n_rob, n_pr;
    logic       accept;
    logic [7:0] rob_sum, pr_sum;
    logic       rob_ovf, pr_ovf;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction

    function automatic logic [7:0] nxt_cnt(input logic [6:0] cur, input logic [2:0] sub,
                                           input logic [2:0] add);
        return {1'b0, cur} - {5'b0, sub} + {5'b0, add};
    endfunction

    function automatic logic [6:0] sat_cnt(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? 7'(lim) : 7'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            rob_free_q <= 7'(ROB_MAX);
            pr_free_q  <= 7'(PR_MAX);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            rob_free_q <= rob_free_d;
            pr_free_q  <= pr_free_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        n_rob  = popcnt4(inst_val_in);
        n_pr   = popcnt4(inst_val_in & pr_need_in);
        // Admission looks only at registered counts; same-cycle returns help next cycle.
        accept = grp_val_in & ~flush_in & ~rst & (state_q != FLUSH) &
                 ({1'b0, rob_free_q} >= {5'b0, n_rob}) & ({1'b0, pr_free_q} >= {5'b0, n_pr});

        grp_ack_out      = accept;
        rob_alloc_en_out = inst_val_in & {4{accept}};
        pr_alloc_en_out  = inst_val_in & pr_need_in & {4{accept}};
        stall_out        = (grp_val_in & ~accept) | (state_q == FLUSH);

        rob_sum = nxt_cnt(rob_free_q, accept ? n_rob : 3'd0, rob_cmt_cnt_in);
        pr_sum  = nxt_cnt(pr_free_q, accept ? n_pr : 3'd0, pr_ret_cnt_in);
        rob_ovf = rob_sum > ROB_MAX;
        pr_ovf  = pr_sum > PR_MAX;

        state_d    = state_q;
        fcnt_d     = fcnt_q;
        rob_free_d = rob_free_q;
        pr_free_d  = sat_cnt(pr_sum, PR_MAX);
        err_d      = err_q | pr_ovf;

        if (flush_in) begin
            // Recovery squashes everything in flight, so the ROB is wholly free again.
            state_d    = FLUSH;
            fcnt_d     = FLUSH_LD;
            rob_free_d = 7'(ROB_MAX);
        end else if (state_q == FLUSH) begin
            if (fcnt_q == '0) state_d = RUN;
            else              fcnt_d  = fcnt_q - FC_W'(1);
        end else begin
            rob_free_d = sat_cnt(rob_sum, ROB_MAX);
            err_d      = err_d | rob_ovf;
            state_d    = (grp_val_in & ~accept) ? STALL : RUN;
        end
    end

    assign rob_free_out = rob_free_q;
    assign pr_free_out  = pr_free_q;
    assign state_out    = state_q;
    assign err_out      = err_q;

endmodule

// File: tb/tb_alloc_ctrl.sv
// Directed bench for alloc_ctrl: walks admission, stall, flush recovery, overflow and reset cases.
module tb_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       grp_val_in;
    logic [3:0] inst_val_in;
    logic [3:0] pr_need_in;
    logic       flush_in;
    logic [2:0] rob_cmt_cnt_in;
    logic [2:0] pr_ret_cnt_in;
    logic       grp_ack_out;
    logic [3:0] rob_alloc_en_out;
    logic [3:0] pr_alloc_en_out;
    logic       stall_out;
    logic [6:0] rob_free_out;
    logic [6:0] pr_free_out;
    logic [1:0] state_out;
    logic       err_out;

    int errors = 0;
    int checks = 0;

    alloc_ctrl #(.ROB_DEPTH(64), .PR_POOL(64), .FLUSH_CYC(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .grp_val_in       (grp_val_in),
        .inst_val_in      (inst_val_in),
        .pr_need_in       (pr_need_in),
        .flush_in         (flush_in),
        .rob_cmt_cnt_in   (rob_cmt_cnt_in),
        .pr_ret_cnt_in    (pr_ret_cnt_in),
        .grp_ack_out      (grp_ack_out),
        .rob_alloc_en_out (rob_alloc_en_out),
        .pr_alloc_en_out  (pr_alloc_en_out),
        .stall_out        (stall_out),
        .rob_free_out     (rob_free_out),
        .pr_free_out      (pr_free_out),
        .state_out        (state_out),
        .err_out          (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d required=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic [3:0] iv, input logic [3:0] nd,
                         input logic fl, input logic [2:0] cm, input logic [2:0] rt);
        grp_val_in     = g;
        inst_val_in    = iv;
        pr_need_in     = nd;
        flush_in       = fl;
        rob_cmt_cnt_in = cm;
        pr_ret_cnt_in  = rt;
        #1;
    endtask

    initial begin
        // reset with every other input active
        rst = 1'b1;
        drive(1'b1, 4'hF, 4'hF, 1'b1, 3'd4, 3'd4);
        chk("rst_ack", grp_ack_out, 0);
        chk("rst_rob_alloc", rob_alloc_en_out, 0);
        chk("rst_pr_alloc", pr_alloc_en_out, 0);
        cyc();
        cyc();
        chk("rst_rob_free", rob_free_out, 64);
        chk("rst_pr_free", pr_free_out, 64);
        chk("rst_state", state_out, 0);
        chk("rst_err", err_out, 0);
        rst = 1'b0;

        // basic group
        drive(1'b1, 4'hF, 4'b1011, 1'b0, 3'd0, 3'd0);
        chk("t1_ack", grp_ack_out, 1);
        chk("t1_rob_alloc", rob_alloc_en_out, 4'hF);
        chk("t1_pr_alloc", pr_alloc_en_out, 4'b1011);
        chk("t1_stall", stall_out, 0);
        cyc();
        chk("t1_rob_free", rob_free_out, 60);
        chk("t1_pr_free", pr_free_out, 61);

        // empty group acked, nothing allocated
        drive(1'b1, 4'h0, 4'hF, 1'b0, 3'd0, 3'd0);
        chk("t2_ack", grp_ack_out, 1);
        chk("t2_rob_alloc", rob_alloc_en_out, 0);
        chk("t2_pr_alloc", pr_alloc_en_out, 0);
        cyc();
        chk("t2_rob_free", rob_free_out, 60);
        chk("t2_pr_free", pr_free_out, 61);

        // drain ROB to 2
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 4'hF, 4'h0, 1'b0, 3'd0, 3'd0);
            cyc();
        end
        drive(1'b1, 4'h3, 4'h0, 1'b0, 3'd0, 3'd0);
        cyc();
        chk("t3_rob_drain", rob_free_out, 2);
        chk("t3_pr_kept", pr_free_out, 61);

        // ROB-short stall and release
        drive(1'b1, 4'h7, 4'h0, 1'b0, 3'd0, 3'd0);
        chk("t3_ack_short", grp_ack_out, 0);
        chk("t3_stall", stall_out, 1);
        cyc();
        chk("t3_state_stall", state_out, 1);
        chk("t3_rob_hold", rob_free_out, 2);
        drive(1'b1, 4'h7, 4'h0, 1'b0, 3'd1, 3'd0);
        chk("t3_ack_commit_same", grp_ack_out, 0);
        cyc();
        chk("t3_rob_cmt", rob_free_out, 3);
        chk("t3_state_still", state_out, 1);
        drive(1'b1, 4'h7, 4'h0, 1'b0, 3'd0, 3'd0);
        chk("t3_ack_exact", grp_ack_out, 1);
        chk("t3_rob_alloc", rob_alloc_en_out, 4'h7);
        cyc();
        chk("t3_rob_zero", rob_free_out, 0);
        chk("t3_state_run", state_out, 0);
        chk("t3_err_zero_ok", err_out, 0);

        // refill ROB with commits
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd4, 3'd0);
            cyc();
        end
        chk("t3_rob_refill", rob_free_out, 64);
        chk("t3_err_refill", err_out, 0);

        // drain PR to 3 while commits keep ROB full
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 4'hF, 4'hF, 1'b0, 3'd4, 3'd0);
            cyc();
        end
        drive(1'b1, 4'h3, 4'h3, 1'b0, 3'd2, 3'd0);
        cyc();
        chk("t4_pr_drain", pr_free_out, 3);
        chk("t4_rob_full", rob_free_out, 64);
        chk("t4_err", err_out, 0);

        // PR-short: same-cycle returns not counted
        drive(1'b1, 4'hF, 4'hF, 1'b0, 3'd0, 3'd4);
        chk("t4_ack_short", grp_ack_out, 0);
        chk("t4_stall", stall_out, 1);
        cyc();
        chk("t4_pr_ret", pr_free_out, 7);
        chk("t4_state_stall", state_out, 1);
        drive(1'b1, 4'hF, 4'hF, 1'b0, 3'd0, 3'd0);
        chk("t4_ack", grp_ack_out, 1);
        chk("t4_pr_alloc", pr_alloc_en_out, 4'hF);
        cyc();
        chk("t4_pr_after", pr_free_out, 3);
        chk("t4_rob_after", rob_free_out, 60);
        chk("t4_state_run", state_out, 0);

        // flush pulse; PR returns keep accumulating, commits ignored
        drive(1'b1, 4'hF, 4'h0, 1'b1, 3'd4, 3'd1);
        chk("t5_ack_flush", grp_ack_out, 0);
        chk("t5_stall_flush", stall_out, 1);
        cyc();
        chk("t5_state_flush", state_out, 2);
        chk("t5_rob_reload", rob_free_out, 64);
        chk("t5_pr_acc", pr_free_out, 4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'hF, 4'h0, 1'b0, 3'd4, 3'd1);
            chk($sformatf("t5_fl%0d_state", i), state_out, 2);
            chk($sformatf("t5_fl%0d_stall", i), stall_out, 1);
            chk($sformatf("t5_fl%0d_ack", i), grp_ack_out, 0);
            chk($sformatf("t5_fl%0d_rob", i), rob_free_out, 64);
            cyc();
        end
        chk("t5_state_run", state_out, 0);
        chk("t5_pr_acc_end", pr_free_out, 8);
        chk("t5_err", err_out, 0);
        drive(1'b1, 4'hF, 4'h0, 1'b0, 3'd0, 3'd0);
        chk("t5_ack_after", grp_ack_out, 1);
        cyc();
        chk("t5_rob_after", rob_free_out, 60);

        // second flush restarted from FLUSH cycle 2
        drive(1'b1, 4'hF, 4'h0, 1'b1, 3'd0, 3'd0);
        cyc();
        chk("t6_state_flush", state_out, 2);
        chk("t6_rob_reload", rob_free_out, 64);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd0);
        cyc();
        drive(1'b0, 4'h0, 4'h0, 1'b1, 3'd0, 3'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd0);
            chk($sformatf("t6_ext%0d_state", i), state_out, 2);
            chk($sformatf("t6_ext%0d_stall_nogrp", i), stall_out, 1);
            cyc();
        end
        chk("t6_state_run", state_out, 0);
        drive(1'b1, 4'hF, 4'h0, 1'b0, 3'd0, 3'd0);
        chk("t6_ack_after", grp_ack_out, 1);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd0);
        cyc();

        // ROB overflow clamps and sets sticky error
        drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd2, 3'd0);
        cyc();
        chk("t7_rob_clamp", rob_free_out, 64);
        chk("t7_err_set", err_out, 1);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0, 3'd0);
        cyc();
        cyc();
        chk("t7_err_sticky", err_out, 1);

        // reset mid-FLUSH beats flush and counts
        drive(1'b0, 4'h0, 4'h0, 1'b1, 3'd0, 3'd0);
        cyc();
        chk("t8_state_flush", state_out, 2);
        rst = 1'b1;
        drive(1'b1, 4'hF, 4'hF, 1'b1, 3'd3, 3'd3);
        chk("t8_rst_ack", grp_ack_out, 0);
        cyc();
        chk("t8_state_run", state_out, 0);
        chk("t8_err_clr", err_out, 0);
        chk("t8_rob", rob_free_out, 64);
        chk("t8_pr", pr_free_out, 64);
        rst = 1'b0;
        drive(1'b1, 4'hF, 4'hF, 1'b0, 3'd0, 3'd0);
        chk("t8_ack_post", grp_ack_out, 1);
        cyc();
        chk("t8_pr_post", pr_free_out, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alloc_ctrl.md
ALLOC_CTRL -- requirements
Module: alloc_ctrl

Interface
REQ-001 Parameter ROB_DEPTH, default 64, number of ROB entries.
REQ-002 Parameter PR_POOL, default 64, number of allocatable physical registers.
REQ-003 Parameter FLUSH_CYC, default 4, cycles spent in recovery after a flush.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 grp_val_in  in  1  decoder presents a 4-slot instruction group.
REQ-007 inst_val_in  in  4  per-slot instruction valid.
REQ-008 pr_need_in  in  4  per-slot destination needs a physical register.
REQ-009 flush_in  in  1  mispredict recovery request.
REQ-010 rob_cmt_cnt_in  in  3  ROB entries retired this cycle, 0..4.
REQ-011 pr_ret_cnt_in  in  3  physical registers returned this cycle, 0..4.
REQ-012 grp_ack_out  out  1  group accepted this cycle.
REQ-013 rob_alloc_en_out  out  4  per-slot ROB write enable.
REQ-014 pr_alloc_en_out  out  4  per-slot free-list pop enable.
REQ-015 stall_out  out  1  group held upstream this cycle.
REQ-016 rob_free_out  out  7  ROB free-entry counter.
REQ-017 pr_free_out  out  7  free physical-register counter.
REQ-018 state_out  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
REQ-019 err_out  out  1  sticky counter overflow/underflow error.

Function
REQ-020 n_rob = popcount(inst_val_in); n_pr = popcount(inst_val_in & pr_need_in); both combinational, 3 bits.
REQ-021 accept = grp_val_in & !flush_in & !rst & state!=FLUSH & rob_free_out>=n_rob & pr_free_out>=n_pr; same-cycle returns/commits are not counted toward accept.
REQ-022 grp_ack_out = accept; rob_alloc_en_out = inst_val_in & {4{accept}}; pr_alloc_en_out = inst_val_in & pr_need_in & {4{accept}}; all-or-nothing, no partial group allocation.
REQ-023 stall_out = grp_val_in & !accept, or state==FLUSH regardless of grp_val_in.
REQ-024 Group with grp_val_in=1 and inst_val_in=0 is acked with zero allocation, counters unchanged by it.
REQ-025 rob_free next = rob_free - (accept ? n_rob : 0) + rob_cmt_cnt_in, computed in 8 bits.
REQ-026 pr_free next = pr_free - (accept ? n_pr : 0) + pr_ret_cnt_in, computed in 8 bits.
REQ-027 Next value > ROB_DEPTH (resp. PR_POOL) clamps to ROB_DEPTH (PR_POOL) and sets err_out; err_out stays 1 until rst.
REQ-028 RUN -> STALL when grp_val_in & !accept & !flush_in; STALL -> RUN on accept or grp_val_in=0.
REQ-029 flush_in=1 in any state: ack forced 0 that cycle; next state FLUSH; flush-cycle counter loaded with FLUSH_CYC-1; rob_free loaded with ROB_DEPTH (rob_cmt_cnt_in ignored that cycle).
REQ-030 pr_free continues to accumulate pr_ret_cnt_in during and on the flush cycle.
REQ-031 In FLUSH: no acks; counter decrements each cycle; at 0 with flush_in=0 next state RUN; flush_in in FLUSH reloads counter (restart); rob_cmt_cnt_in ignored while in FLUSH.
REQ-032 Exactly full counters (rob_free_out=n_rob, pr_free_out=n_pr) accept; counters reaching 0 is legal and not an error.

Reset
REQ-033 On rst: rob_free_out=ROB_DEPTH, pr_free_out=PR_POOL, state RUN, flush counter 0, err_out=0; grp_ack_out, rob_alloc_en_out, pr_alloc_en_out=0 while rst=1.
REQ-034 rst takes priority over flush_in and all count inputs; reset mid-FLUSH returns to RUN next cycle.

Verification
REQ-035 After reset, grp_val=1, inst_val=4'hF, pr_need=4'b1011 -> ack=1, rob_alloc=4'hF, pr_alloc=4'b1011; next cycle rob_free=60, pr_free=61.
REQ-036 rob_free=2, group inst_val=4'h7 -> ack=0, stall=1, state STALL; rob_cmt_cnt=1 -> next cycle rob_free=3, ack=1, state RUN.
REQ-037 pr_free=3, group pr_need&val=4'hF, pr_ret_cnt=4 same cycle -> ack=0 that cycle; next cycle pr_free=7, ack=1, pr_free then 3.
REQ-038 flush_in pulse with grp_val=1 -> ack=0; 4 cycles state=2, stall=1, rob_free=64; cycle 5 state RUN, ack=1; second flush at FLUSH cycle 2 extends FLUSH to 4 cycles from that point.
REQ-039 rob_free=64, rob_cmt_cnt=2 -> rob_free stays 64, err_out=1 and holds until rst.
REQ-040 grp_val=1, inst_val=0 -> ack=1, all enables 0, counters unchanged.
